// File: rtl/box_draw_engine.sv
// box_draw_engine: rectangle plotter for the VGA frame-buffer path.
// Latches an origin/colour on start, then scans BOX_W x BOX_H pixels in
// row-major order, one per clock, followed by a one-cycle done pulse.
// Optional feature macro: BOX_DRAW_CLIP_EN (per-pixel clipping instead of
// origin clamping).
module box_draw_engine #(
  parameter int                   X_W       = 8,
  parameter int                   Y_W       = 7,
  parameter int                   COLOUR_W  = 3,
  parameter int                   BOX_W     = 4,
  parameter int                   BOX_H     = 4,
  parameter int                   X_MAX     = 159,
  parameter int                   Y_MAX     = 119,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                erase,
  output logic                busy,
  output logic                done,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  localparam int CX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int CY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam logic [CX_W-1:0] CX_LAST = CX_W'(BOX_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(BOX_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [X_W-1:0]      ox_q, ox_d;
  logic [Y_W-1:0]      oy_q, oy_d;
  logic [CX_W-1:0]     cx_q, cx_d;
  logic [CY_W-1:0]     cy_q, cy_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [X_W-1:0]      ox_in;
  logic [Y_W-1:0]      oy_in;
  logic                on_screen;

`ifdef BOX_DRAW_CLIP_EN
  // One extra bit on each sum so a wrap past the top of the range is seen
  // as off-screen rather than folding back onto the left/top edge.
  localparam logic [X_W:0] X_MAX_E = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0] Y_MAX_E = (Y_W+1)'(Y_MAX);
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;

  // Unclamped origin; pixels beyond the visible area are suppressed.
  always_comb begin
    ox_in     = x_in;
    oy_in     = y_in;
    x_sum     = {1'b0, ox_q} + (X_W+1)'(cx_q);
    y_sum     = {1'b0, oy_q} + (Y_W+1)'(cy_q);
    x         = x_sum[X_W-1:0];
    y         = y_sum[Y_W-1:0];
    on_screen = (x_sum <= X_MAX_E) && (y_sum <= Y_MAX_E);
  end
`else
  // Largest origin that still keeps the whole box on screen.
  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX - BOX_W + 1);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX - BOX_H + 1);

  // Clamp the origin so every pixel lands on screen; sums cannot wrap.
  always_comb begin
    ox_in     = (x_in > X_LIM) ? X_LIM : x_in;
    oy_in     = (y_in > Y_LIM) ? Y_LIM : y_in;
    x         = ox_q + X_W'(cx_q);
    y         = oy_q + Y_W'(cy_q);
    on_screen = 1'b1;
  end
`endif

  // Next-state and scan-counter logic; counters are left untouched on the
  // final pixel so x/y keep showing it through DONE and IDLE.
  always_comb begin
    state_d  = state_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    colour_d = colour_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_DRAW;
          ox_d     = ox_in;
          oy_d     = oy_in;
          cx_d     = '0;
          cy_d     = '0;
          colour_d = erase ? BG_COLOUR : colour_in;
        end
      end
      S_DRAW: begin
        if (cx_q == CX_LAST) begin
          if (cy_q == CY_LAST) begin
            state_d = S_DONE;
          end else begin
            cx_d = '0;
            cy_d = cy_q + CY_W'(1);
          end
        end else begin
          cx_d = cx_q + CX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      ox_q     <= '0;
      oy_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      colour_q <= colour_d;
    end
  end

  // Status and pixel strobes decoded from the state register.
  always_comb begin
    busy   = (state_q == S_DRAW) || (state_q == S_DONE);
    done   = (state_q == S_DONE);
    plot   = (state_q == S_DRAW) && on_screen;
    colour = colour_q;
  end

endmodule

// File: tb/tb_box_draw_engine.sv
// Scoreboard bench for box_draw_engine: the stimulus pushes the expected
// pixel/done events with their cycle stamps, a negedge monitor pops and
// compares every plot or done the DUT presents.
module tb_box_draw_engine;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic       erase = 1'b0;
  logic       busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  box_draw_engine dut (
    .clk(clk), .resetn(resetn), .start(start), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .erase(erase), .busy(busy), .done(done),
    .plot(plot), .x(x), .y(y), .colour(colour)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_done;
    int         cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every plot or done cycle must match the head of the queue.
  always @(negedge clk) begin
    if (plot || done) begin
      checks++;
      if (plot && done) begin
        errors++;
        $display("FAIL strobe cyc=%0d plot and done both high", cyc);
      end else if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected cyc=%0d got done=%0b x=%0d y=%0d c=%0d, none expected",
                 cyc, done, x, y, colour);
      end else begin
        ev_t e;
        e = expq.pop_front();
        if (e.is_done != done || e.cyc != cyc ||
            (!e.is_done && (e.x != x || e.y != y || e.c != colour))) begin
          errors++;
          $display("FAIL event got done=%0b cyc=%0d x=%0d y=%0d c=%0d, want done=%0b cyc=%0d x=%0d y=%0d c=%0d",
                   done, cyc, x, y, colour, e.is_done, e.cyc, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Issue one box. stop_at>=0 pulls reset while pixel stop_at is shown;
  // restart_at>=0 pulses an (ignored) start with x_in=50 at that pixel.
  task automatic run_box(input logic [7:0] xi, input logic [6:0] yi,
                         input logic [2:0] ci, input logic er,
                         input logic [7:0] eox, input logic [6:0] eoy,
                         input logic [2:0] ec, input int stop_at, input int restart_at);
    int k;
    @(negedge clk);
    x_in = xi; y_in = yi; colour_in = ci; erase = er; start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0;
    x_in = 8'd200; y_in = 7'd5; colour_in = ~ci; erase = ~er;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        int   idx;
        logic vis;
        ev_t  e;
        idx = j * 4 + i;
        vis = 1'b1;
`ifdef BOX_DRAW_CLIP_EN
        vis = (int'(eox) + i <= 159) && (int'(eoy) + j <= 119);
`endif
        if ((stop_at < 0 || idx <= stop_at) && vis) begin
          e.is_done = 1'b0; e.cyc = k + idx;
          e.x = eox + 8'(i); e.y = eoy + 7'(j); e.c = ec;
          expq.push_back(e);
        end
      end
    end
    if (stop_at < 0) begin
      ev_t d;
      d.is_done = 1'b1; d.cyc = k + 16; d.x = '0; d.y = '0; d.c = '0;
      expq.push_back(d);
    end
    for (int t = 0; t < 17; t++) begin
      if (t == restart_at) begin start = 1'b1; x_in = 8'd50; end
      if (t == stop_at) resetn = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      if (t == stop_at) begin
        check("rst_plot", 32'(plot), 0);
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        resetn = 1'b1;
        return;
      end
      if (t == 15) check("busy_in_done", 32'(busy), 1);
    end
    check("busy_after", 32'(busy), 0);
    check("plot_after", 32'(plot), 0);
    check("hold_x", 32'(x), 32'(eox + 8'd3));
    check("hold_y", 32'(y), 32'(eoy + 7'd3));
    check("hold_c", 32'(colour), 32'(ec));
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", 32'(x), 0);
    check("reset_y", 32'(y), 0);
    check("reset_plot", 32'(plot), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_colour", 32'(colour), 0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    run_box(8'd10, 7'd10, 3'b100, 1'b0, 8'd10, 7'd10, 3'b100, -1, -1);
`ifdef BOX_DRAW_CLIP_EN
    run_box(8'd158, 7'd10, 3'b010, 1'b0, 8'd158, 7'd10, 3'b010, -1, -1);
    run_box(8'd158, 7'd118, 3'b011, 1'b0, 8'd158, 7'd118, 3'b011, -1, -1);
`else
    run_box(8'd158, 7'd118, 3'b010, 1'b0, 8'd156, 7'd116, 3'b010, -1, -1);
    run_box(8'd0, 7'd0, 3'b011, 1'b0, 8'd0, 7'd0, 3'b011, -1, -1);
`endif
    run_box(8'd20, 7'd30, 3'b001, 1'b0, 8'd20, 7'd30, 3'b001, -1, 5);
    run_box(8'd40, 7'd40, 3'b111, 1'b1, 8'd40, 7'd40, 3'b000, -1, -1);
    run_box(8'd60, 7'd50, 3'b101, 1'b0, 8'd60, 7'd50, 3'b101, 7, -1);
    repeat (2) @(posedge clk);
    run_box(8'd70, 7'd60, 3'b110, 1'b0, 8'd70, 7'd60, 3'b110, -1, -1);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
